id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX/MEM and MEM/WB operand
// forwarding, and immediate sign extension. It drives the ALU X/Y operands and the opcode.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_op,
  input  logic [3:0]        id_ctrl,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_dest,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_dest,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_dest,
  output logic [3:0]        ex_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [2:0]        alu_opcod,
  output logic [DATA_W-1:0] ex_store_data
);

  // Control bundle bit positions: {mem_read, mem_write, reg_write, mem_to_reg}.
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_MEM_WRITE = 2;

  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_dest;
  logic [3:0]        r_ex_ctrl;
  logic [2:0]        r_alu_op;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [IMM_W-1:0]  r_imm;
  logic              r_alu_src;

  logic              w_stall;
  logic              w_rt_used;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_imm_ext;

  // The rt field matters to a hazard when it feeds the ALU or is the data being stored.
  assign w_rt_used = !id_alu_src || id_ctrl[CTRL_MEM_WRITE];
  assign w_stall   = r_ex_valid && r_ex_ctrl[CTRL_MEM_READ] && (r_ex_dest != '0) &&
                     id_valid && ((r_ex_dest == id_rs) || ((r_ex_dest == id_rt) && w_rt_used));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every pipeline register sampling pre-edge values.
    if (rst || flush || w_stall) begin
      r_ex_valid <= 1'b0;
      r_ex_dest  <= '0;
      r_ex_ctrl  <= '0;
      r_alu_op   <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_alu_src  <= 1'b0;
    end else begin
      r_ex_valid <= id_valid;
      r_ex_dest  <= id_dest;
      r_ex_ctrl  <= id_valid ? id_ctrl : 4'b0000;
      r_alu_op   <= id_alu_op;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_alu_src  <= id_alu_src;
    end
  end

  // Register 0 always reads as zero; EX/MEM wins over MEM/WB as the younger result.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] reg_val,
    input logic              em_we,
    input logic [REG_AW-1:0] em_dest,
    input logic [DATA_W-1:0] em_val,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_dest,
    input logic [DATA_W-1:0] mw_val
  );
    if (src == '0)                        return '0;
    else if (em_we && (em_dest == src))   return em_val;
    else if (mw_we && (mw_dest == src))   return mw_val;
    else                                  return reg_val;
  endfunction

  assign w_fwd_a   = fwd_operand(r_rs, r_rs_data, exmem_reg_write, exmem_dest, exmem_result,
                                 memwb_reg_write, memwb_dest, memwb_result);
  assign w_fwd_b   = fwd_operand(r_rt, r_rt_data, exmem_reg_write, exmem_dest, exmem_result,
                                 memwb_reg_write, memwb_dest, memwb_result);
  assign w_imm_ext = {{(DATA_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};

  assign stall         = w_stall;
  assign ex_valid      = r_ex_valid;
  assign ex_dest       = r_ex_dest;
  assign ex_ctrl       = r_ex_ctrl;
  assign alu_opcod     = r_alu_op;
  assign alu_x         = w_fwd_a;
  assign alu_y         = r_alu_src ? w_imm_ext : w_fwd_b;
  assign ex_store_data = w_fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX-stage contents are queued as each
// instruction is driven and compared one edge later.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_alu_src;
  logic [2:0]  id_rs, id_rt, id_dest, id_alu_op;
  logic [15:0] id_rs_data, id_rt_data;
  logic [5:0]  id_imm;
  logic [3:0]  id_ctrl;
  logic        exmem_reg_write, memwb_reg_write;
  logic [2:0]  exmem_dest, memwb_dest;
  logic [15:0] exmem_result, memwb_result;
  logic        stall, ex_valid;
  logic [2:0]  ex_dest, alu_opcod;
  logic [3:0]  ex_ctrl;
  logic [15:0] alu_x, alu_y, ex_store_data;

  id_ex_stage #(.DATA_W(16), .REG_AW(3), .IMM_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
    .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
    .alu_x(alu_x), .alu_y(alu_y), .alu_opcod(alu_opcod), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  // full=0 marks a bubble: only valid, ctrl and opcode are defined for it.
  typedef struct {
    logic        full;
    logic        v;
    logic [2:0]  dest;
    logic [3:0]  ctrl;
    logic [2:0]  op;
    logic [15:0] x, y, sd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push_full(input logic v, input logic [2:0] dest, input logic [3:0] ctrl,
                           input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] sd);
    exp_t e;
    e.full = 1'b1; e.v = v; e.dest = dest; e.ctrl = ctrl; e.op = op;
    e.x = x; e.y = y; e.sd = sd;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e.full = 1'b0; e.v = 1'b0; e.dest = '0; e.ctrl = '0; e.op = '0;
    e.x = '0; e.y = '0; e.sd = '0;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_valid"}, ex_valid, e.v);
      check({tag, "_ctrl"}, ex_ctrl, e.ctrl);
      check({tag, "_opcod"}, alu_opcod, e.op);
      if (e.full) begin
        check({tag, "_dest"}, ex_dest, e.dest);
        check({tag, "_alu_x"}, alu_x, e.x);
        check({tag, "_alu_y"}, alu_y, e.y);
        check({tag, "_store"}, ex_store_data, e.sd);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] dest, input logic [15:0] rs_d, input logic [15:0] rt_d,
                       input logic [5:0] imm, input logic src, input logic [2:0] op,
                       input logic [3:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_dest = dest;
    id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm;
    id_alu_src = src; id_alu_op = op; id_ctrl = ctrl;
  endtask

  task automatic fwd(input logic ew, input logic [2:0] ed, input logic [15:0] er,
                     input logic mw, input logic [2:0] md, input logic [15:0] mr);
    exmem_reg_write = ew; exmem_dest = ed; exmem_result = er;
    memwb_reg_write = mw; memwb_dest = md; memwb_result = mr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    drive(1'b1, 3'd1, 3'd2, 3'd3, 16'hAAAA, 16'hBBBB, 6'h15, 1'b1, 3'b101, 4'b1111);
    push_full(1'b0, 3'd0, 4'b0000, 3'b000, 16'h0, 16'h0, 16'h0);
    tick("reset");
    check("reset_stall", stall, 1'b0);
    rst = 1'b0;

    // Plain add, no forwarding.
    drive(1'b1, 3'd1, 3'd2, 3'd4, 16'h0003, 16'h0004, 6'h00, 1'b0, 3'b000, 4'b0010);
    #1 check("add_stall", stall, 1'b0);
    push_full(1'b1, 3'd4, 4'b0010, 3'b000, 16'h0003, 16'h0004, 16'h0004);
    tick("add");

    // Both forwarding paths match rs=2; EX/MEM must win.
    fwd(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222);
    drive(1'b1, 3'd2, 3'd5, 3'd6, 16'h00AA, 16'h0055, 6'h00, 1'b0, 3'b001, 4'b0010);
    push_full(1'b1, 3'd6, 4'b0010, 3'b001, 16'h1111, 16'h0055, 16'h0055);
    tick("fwd_both");
    fwd(1'b0, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222);
    #1 check("fwd_memwb_x", alu_x, 16'h2222);
    fwd(1'b0, 3'd2, 16'h1111, 1'b1, 3'd5, 16'h2222);
    #1 check("fwd_memwb_rt_x", alu_x, 16'h00AA);
    check("fwd_memwb_rt_y", alu_y, 16'h2222);
    check("fwd_memwb_rt_sd", ex_store_data, 16'h2222);
    fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

    // Load to r3, then a dependent add: one stall cycle and one bubble.
    drive(1'b1, 3'd1, 3'd3, 3'd3, 16'h0100, 16'h0007, 6'h04, 1'b1, 3'b000, 4'b1010);
    #1 check("load_stall", stall, 1'b0);
    push_full(1'b1, 3'd3, 4'b1010, 3'b000, 16'h0100, 16'h0004, 16'h0007);
    tick("load");
    drive(1'b1, 3'd3, 3'd1, 3'd5, 16'h0009, 16'h0002, 6'h00, 1'b0, 3'b000, 4'b0010);
    #1 check("use_stall", stall, 1'b1);
    push_bubble();
    tick("use_bubble");
    check("use_unstall", stall, 1'b0);
    push_full(1'b1, 3'd5, 4'b0010, 3'b000, 16'h0009, 16'h0002, 16'h0002);
    tick("use_enter");

    // Store with negative immediate; store data still forwarded from MEM/WB.
    fwd(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'hBEEF);
    drive(1'b1, 3'd1, 3'd2, 3'd0, 16'h0010, 16'h1234, 6'b111110, 1'b1, 3'b000, 4'b0100);
    #1 check("imm_stall", stall, 1'b0);
    push_full(1'b1, 3'd0, 4'b0100, 3'b000, 16'h0010, 16'hFFFE, 16'hBEEF);
    tick("imm");
    fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

    // Load to r4, then rt-only dependency: immediate ALU op ignores rt, a store does not.
    drive(1'b1, 3'd1, 3'd2, 3'd4, 16'h0001, 16'h0002, 6'h01, 1'b1, 3'b000, 4'b1010);
    push_full(1'b1, 3'd4, 4'b1010, 3'b000, 16'h0001, 16'h0001, 16'h0002);
    tick("load2");
    drive(1'b1, 3'd1, 3'd4, 3'd5, 16'h0001, 16'h0002, 6'h01, 1'b1, 3'b000, 4'b0010);
    #1 check("rt_imm_nostall", stall, 1'b0);
    drive(1'b1, 3'd1, 3'd4, 3'd0, 16'h0001, 16'h0002, 6'h01, 1'b1, 3'b000, 4'b0100);
    #1 check("rt_store_stall", stall, 1'b1);

    // Flush together with stall loads a bubble.
    drive(1'b1, 3'd4, 3'd1, 3'd5, 16'h0000, 16'h0003, 6'h00, 1'b0, 3'b011, 4'b0010);
    flush = 1'b1;
    #1 check("flush_stall", stall, 1'b1);
    push_bubble();
    tick("flush");
    flush = 1'b0;

    // Reset mid-stream with a valid instruction presented.
    drive(1'b1, 3'd1, 3'd2, 3'd6, 16'h0005, 16'h0006, 6'h3F, 1'b1, 3'b011, 4'b0010);
    rst = 1'b1;
    push_full(1'b0, 3'd0, 4'b0000, 3'b000, 16'h0, 16'h0, 16'h0);
    tick("rst_mid");
    check("rst_mid_stall", stall, 1'b0);
    rst = 1'b0;

    // Invalid instruction: control squashed, rest of the fields still loaded.
    drive(1'b0, 3'd1, 3'd2, 3'd2, 16'h0005, 16'h0006, 6'h00, 1'b0, 3'b010, 4'b1111);
    push_full(1'b0, 3'd2, 4'b0000, 3'b010, 16'h0005, 16'h0006, 16'h0006);
    tick("invalid");

    // Register 0 operands read zero even when forwarding paths name r0.
    fwd(1'b1, 3'd0, 16'h5555, 1'b1, 3'd0, 16'h6666);
    drive(1'b1, 3'd0, 3'd0, 3'd1, 16'h7777, 16'h8888, 6'h00, 1'b0, 3'b000, 4'b0010);
    #1 check("r0_stall", stall, 1'b0);
    push_full(1'b1, 3'd1, 4'b0010, 3'b000, 16'h0000, 16'h0000, 16'h0000);
    tick("r0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
